// File: rtl/ddr3_mem_pkg.sv
// Shared types for the DDR3 controller CPU port: CPU command codes,
// port FSM states and the default burst length.
package ddr3_mem_pkg;

    localparam int unsigned BURST_LEN_DEF = 32'd8;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_WRITE = 3'd1,
        CMD_READ  = 3'd2
    } cpu_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_PULL    = 3'd1,
        ST_WR_ISSUE   = 3'd2,
        ST_WR_PUSH    = 3'd3,
        ST_RD_ISSUE   = 3'd4,
        ST_RD_COLLECT = 3'd5,
        ST_RD_RETURN  = 3'd6
    } port_state_t;

    // Only WRITE and READ start a transaction; NOP and undefined codes are dropped
    function automatic logic cmd_is_legal(input logic [2:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/ddr3_burst_buf.sv
// Burst buffer: DEPTH x DATA_W register file with independent write and
// read pointers. srst clears contents and pointers in one cycle, which is
// how a completed or abandoned burst is discarded. Read data is the entry
// at the read pointer (combinational), so the owner registers it.
module ddr3_burst_buf #(
    parameter int unsigned DATA_W = 32'd64,
    parameter int unsigned DEPTH  = 32'd8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              srst,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;

    // Storage and pointer update; clear has priority over a same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (srst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (we) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (re) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    assign rdata = mem_r[rd_ptr_r];

endmodule

// File: rtl/ddr3_cont_cpu_port.sv
// CPU-side port of the DDR3 memory controller. Accepts READ/WRITE from
// the CPU, pulls write bursts into a burst buffer, hands commands to the
// DDR3 sequencer over req/ack, and returns collected read bursts.
// Optional feature: define DDR3_CPU_RD_TIMEOUT_EN to abort a read whose
// beats do not all arrive within RD_TIMEOUT cycles of mc_ack (RD_ERR pulse).
module ddr3_cont_cpu_port
    import ddr3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32'd25,
    parameter int unsigned BA_W       = 32'd3,
    parameter int unsigned DATA_W     = 32'd64,
    parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
    parameter int unsigned RD_TIMEOUT = 32'd64
) (
    input  logic              cpu_clk,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [BA_W-1:0]   BA,
    input  logic [2:0]        CMD,
    input  logic              ADDR_VALID,
    output logic              CMD_RDY,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_DATA_VALID,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_DATA_VALID,
    output logic              RD_ERR,
    input  logic              mc_init_done,
    output logic              mc_req,
    output logic              mc_we,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [BA_W-1:0]   mc_ba,
    input  logic              mc_ack,
    output logic [DATA_W-1:0] mc_wdata,
    output logic              mc_wdata_valid,
    input  logic [DATA_W-1:0] mc_rdata,
    input  logic              mc_rdata_valid
);

    // Burst geometry must allow a power-of-2 buffer with at least two beats
    if ((BURST_LEN < 32'd2) || ((BURST_LEN & (BURST_LEN - 32'd1)) != 32'd0) ||
        (RD_TIMEOUT < 32'd1)) begin : g_bad_params
        $error("ddr3_cont_cpu_port: BURST_LEN must be a power of 2 >= 2, RD_TIMEOUT >= 1");
    end

    localparam int unsigned     CW        = $clog2(BURST_LEN);
    localparam logic [CW-1:0]   BEAT_LAST = CW'(BURST_LEN - 32'd1);

    port_state_t       state_r;
    logic [CW-1:0]     beat_r;
    logic              beat_term_s;
    logic              accept_s;
    logic              to_hit_s;

    logic              buf_we_s;
    logic              buf_re_s;
    logic              buf_srst_s;
    logic [DATA_W-1:0] buf_wdata_s;
    logic [DATA_W-1:0] buf_rdata_s;

    logic              cmd_rdy_r;
    logic              wr_data_valid_r;
    logic              rd_data_valid_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_err_r;
    logic              mc_req_r;
    logic              mc_we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [BA_W-1:0]   ba_r;
    logic [DATA_W-1:0] mc_wdata_r;
    logic              mc_wdata_valid_r;

`ifdef DDR3_CPU_RD_TIMEOUT_EN
    localparam int unsigned   TW      = $clog2(RD_TIMEOUT + 32'd1);
    localparam logic [TW-1:0] TO_LAST = TW'(RD_TIMEOUT - 32'd1);

    logic [TW-1:0] to_cnt_r;

    // Read timeout counter: restarts on the read ack, advances each collect cycle
    always_ff @(posedge cpu_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            to_cnt_r <= '0;
        end else if ((state_r == ST_RD_ISSUE) && mc_ack) begin
            to_cnt_r <= '0;
        end else if (state_r == ST_RD_COLLECT) begin
            to_cnt_r <= to_cnt_r + 1'b1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // A final beat arriving on the deadline cycle still completes the burst
    assign to_hit_s = (state_r == ST_RD_COLLECT) && (to_cnt_r == TO_LAST) &&
                      !(mc_rdata_valid && beat_term_s);
`else
    assign to_hit_s = 1'b0;
`endif

    // Buffer steering and command acceptance for the current state
    always_comb begin
        beat_term_s = (beat_r == BEAT_LAST);
        accept_s    = 1'b0;
        buf_we_s    = 1'b0;
        buf_re_s    = 1'b0;
        buf_srst_s  = 1'b0;
        buf_wdata_s = WR_DATA;
        case (state_r)
            ST_IDLE: begin
                accept_s   = ADDR_VALID && cmd_rdy_r && cmd_is_legal(CMD);
                buf_srst_s = accept_s;
            end
            ST_WR_PULL: begin
                buf_we_s    = 1'b1;
                buf_wdata_s = WR_DATA;
            end
            ST_WR_ISSUE: begin
                buf_re_s = mc_ack;
            end
            ST_WR_PUSH: begin
                buf_re_s = !beat_term_s;
            end
            ST_RD_COLLECT: begin
                buf_we_s    = mc_rdata_valid;
                buf_wdata_s = mc_rdata;
                buf_re_s    = mc_rdata_valid && beat_term_s;
                buf_srst_s  = to_hit_s;
            end
            ST_RD_RETURN: begin
                buf_re_s = !beat_term_s;
            end
            default: begin
                buf_srst_s = 1'b1;
            end
        endcase
    end

    // Port FSM with all CPU/sequencer outputs registered
    always_ff @(posedge cpu_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r          <= ST_IDLE;
            beat_r           <= '0;
            cmd_rdy_r        <= 1'b0;
            wr_data_valid_r  <= 1'b0;
            rd_data_valid_r  <= 1'b0;
            rd_data_r        <= '0;
            rd_err_r         <= 1'b0;
            mc_req_r         <= 1'b0;
            mc_we_r          <= 1'b0;
            addr_r           <= '0;
            ba_r             <= '0;
            mc_wdata_r       <= '0;
            mc_wdata_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rd_err_r <= 1'b0;
                    if (accept_s) begin
                        cmd_rdy_r <= 1'b0;
                        addr_r    <= ADDR;
                        ba_r      <= BA;
                        beat_r    <= '0;
                        if (CMD == CMD_WRITE) begin
                            mc_we_r         <= 1'b1;
                            wr_data_valid_r <= 1'b1;
                            state_r         <= ST_WR_PULL;
                        end else begin
                            mc_we_r  <= 1'b0;
                            mc_req_r <= 1'b1;
                            state_r  <= ST_RD_ISSUE;
                        end
                    end else begin
                        cmd_rdy_r <= mc_init_done;
                    end
                end
                ST_WR_PULL: begin
                    if (beat_term_s) begin
                        beat_r          <= '0;
                        wr_data_valid_r <= 1'b0;
                        mc_req_r        <= 1'b1;
                        state_r         <= ST_WR_ISSUE;
                    end else begin
                        beat_r <= beat_r + 1'b1;
                    end
                end
                ST_WR_ISSUE: begin
                    if (mc_ack) begin
                        mc_req_r         <= 1'b0;
                        mc_wdata_r       <= buf_rdata_s;
                        mc_wdata_valid_r <= 1'b1;
                        beat_r           <= '0;
                        state_r          <= ST_WR_PUSH;
                    end
                end
                ST_WR_PUSH: begin
                    if (beat_term_s) begin
                        mc_wdata_r       <= '0;
                        mc_wdata_valid_r <= 1'b0;
                        beat_r           <= '0;
                        state_r          <= ST_IDLE;
                    end else begin
                        mc_wdata_r <= buf_rdata_s;
                        beat_r     <= beat_r + 1'b1;
                    end
                end
                ST_RD_ISSUE: begin
                    if (mc_ack) begin
                        mc_req_r <= 1'b0;
                        beat_r   <= '0;
                        state_r  <= ST_RD_COLLECT;
                    end
                end
                ST_RD_COLLECT: begin
                    if (mc_rdata_valid && beat_term_s) begin
                        rd_data_r       <= buf_rdata_s;
                        rd_data_valid_r <= 1'b1;
                        beat_r          <= '0;
                        state_r         <= ST_RD_RETURN;
                    end else if (to_hit_s) begin
                        rd_err_r <= 1'b1;
                        beat_r   <= '0;
                        state_r  <= ST_IDLE;
                    end else if (mc_rdata_valid) begin
                        beat_r <= beat_r + 1'b1;
                    end
                end
                ST_RD_RETURN: begin
                    if (beat_term_s) begin
                        rd_data_r       <= '0;
                        rd_data_valid_r <= 1'b0;
                        beat_r          <= '0;
                        state_r         <= ST_IDLE;
                    end else begin
                        rd_data_r <= buf_rdata_s;
                        beat_r    <= beat_r + 1'b1;
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    beat_r           <= '0;
                    cmd_rdy_r        <= 1'b0;
                    wr_data_valid_r  <= 1'b0;
                    rd_data_valid_r  <= 1'b0;
                    rd_data_r        <= '0;
                    rd_err_r         <= 1'b0;
                    mc_req_r         <= 1'b0;
                    mc_wdata_r       <= '0;
                    mc_wdata_valid_r <= 1'b0;
                end
            endcase
        end
    end

    ddr3_burst_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BURST_LEN)
    ) u_buf (
        .clk   (cpu_clk),
        .rst_n (RESET_N),
        .srst  (buf_srst_s),
        .we    (buf_we_s),
        .wdata (buf_wdata_s),
        .re    (buf_re_s),
        .rdata (buf_rdata_s)
    );

    assign CMD_RDY        = cmd_rdy_r;
    assign WR_DATA_VALID  = wr_data_valid_r;
    assign RD_DATA        = rd_data_r;
    assign RD_DATA_VALID  = rd_data_valid_r;
    assign RD_ERR         = rd_err_r;
    assign mc_req         = mc_req_r;
    assign mc_we          = mc_we_r;
    assign mc_addr        = addr_r;
    assign mc_ba          = ba_r;
    assign mc_wdata       = mc_wdata_r;
    assign mc_wdata_valid = mc_wdata_valid_r;

endmodule
